// File: rtl/range_sum_arbiter.sv
// range_sum_arbiter
//   Round-robin arbiter in front of a sequential range-sum engine. Each
//   requester supplies an inclusive range [lo, hi]. The winning job is
//   summed one term per cycle, and the sum is reported with a one-cycle
//   completion pulse.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   req           per-requester pending-job flags
//   lo / hi       per-requester bounds, requester i in slice [i*W +: W]
//   grant         one-hot job acceptance (combinational, IDLE only)
//   busy          engine is not IDLE
//   result        inclusive sum of the last completed job (2*W bits)
//   result_valid  one-cycle completion pulse
//   result_id     requester index of the completed job
//   err           with result_valid: the job had lo > hi
module range_sum_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*W-1:0]         lo,
    input  logic [N_REQ*W-1:0]         hi,
    output logic [N_REQ-1:0]           grant,
    output logic                       busy,
    output logic [2*W-1:0]             result,
    output logic                       result_valid,
    output logic [$clog2(N_REQ)-1:0]   result_id,
    output logic                       err
);

    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   id_q, id_d;
    logic [W-1:0]    idx_q, idx_d;
    logic [W-1:0]    hi_q, hi_d;
    logic            inv_q, inv_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [2*W-1:0]  result_q, result_d;
    logic [IW-1:0]   result_id_q, result_id_d;
    logic            err_q, err_d;

    logic            found;
    logic [IW-1:0]   win;
    logic [W-1:0]    win_lo, win_hi;

    // Search upward from ptr_q; the IW-bit sum wraps modulo N_REQ because
    // N_REQ is a power of two.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!found && req[ptr_q + IW'(k)]) begin
                found = 1'b1;
                win   = ptr_q + IW'(k);
            end
        end
        win_lo = lo[win*W +: W];
        win_hi = hi[win*W +: W];
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        idx_d       = idx_q;
        hi_d        = hi_q;
        inv_d       = inv_q;
        acc_d       = acc_q;
        result_d    = result_q;
        result_id_d = result_id_q;
        err_d       = err_q;
        grant       = '0;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    // Gated by rst_n so grant is forced low during reset.
                    grant[win] = rst_n;
                    state_d    = RUN;
                    ptr_d      = win + 1'b1;
                    id_d       = win;
                    idx_d      = win_lo;
                    hi_d       = win_hi;
                    inv_d      = (win_lo > win_hi);
                    acc_d      = '0;
                end
            end
            RUN: begin
                if (inv_q) begin
                    state_d     = DONE;
                    result_d    = '0;
                    result_id_d = id_q;
                    err_d       = 1'b1;
                end else begin
                    acc_d = acc_q + {{W{1'b0}}, idx_q};
                    // Compare before incrementing so hi = 2^W-1 never wraps idx.
                    if (idx_q == hi_q) begin
                        state_d     = DONE;
                        result_d    = acc_d;
                        result_id_d = id_q;
                        err_d       = 1'b0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            idx_q       <= '0;
            hi_q        <= '0;
            inv_q       <= 1'b0;
            acc_q       <= '0;
            result_q    <= '0;
            result_id_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            idx_q       <= idx_d;
            hi_q        <= hi_d;
            inv_q       <= inv_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            result_id_q <= result_id_d;
            err_q       <= err_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign result_valid = (state_q == DONE);
    assign result       = result_q;
    assign result_id    = result_id_q;
    assign err          = err_q;

endmodule

// File: tb/tb_range_sum_arbiter.sv
module tb_range_sum_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*W-1:0]  lo_bus, hi_bus;
    logic [N-1:0]    grant;
    logic            busy;
    logic [2*W-1:0]  result;
    logic            result_valid;
    logic [1:0]      result_id;
    logic            err;

    range_sum_arbiter #(.N_REQ(N), .W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .lo           (lo_bus),
        .hi           (hi_bus),
        .grant        (grant),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_id    (result_id),
        .err          (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: pending set, per-requester operands, round-robin pointer,
    // last reported result (which must hold between completions).
    logic [N-1:0] pend;
    int           lo_a [N];
    int           hi_a [N];
    int           ptr_m;
    int           last_res;
    int           last_id;
    int           last_err;
    int           w_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sum_range(input int l, input int h);
        if (l > h) return 0;
        return (h * (h + 1) - l * (l - 1)) / 2;
    endfunction

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            if (pend[(ptr_m + k) % N]) return (ptr_m + k) % N;
        end
        return -1;
    endfunction

    task automatic drive_bus();
        req = pend;
        for (int i = 0; i < N; i++) begin
            lo_bus[i*W +: W] = lo_a[i][W-1:0];
            hi_bus[i*W +: W] = hi_a[i][W-1:0];
        end
    endtask

    // Entered at a negedge with the DUT in IDLE; leaves at a negedge in IDLE.
    task automatic serve(output int w);
        int cycles;
        int exp_lat;
        int exp_sum;
        int exp_err;
        logic [N-1:0] onehot;
        drive_bus();
        #1;
        w = pick();
        onehot = '0;
        if (w >= 0) onehot[w] = 1'b1;
        check("grant", 32'(grant), 32'(onehot));
        check("busy_at_grant", 32'(busy), 32'd0);
        if (w < 0) return;
        exp_err = (lo_a[w] > hi_a[w]) ? 1 : 0;
        exp_sum = sum_range(lo_a[w], hi_a[w]);
        exp_lat = exp_err ? 2 : (hi_a[w] - lo_a[w] + 2);
        @(posedge clk);
        ptr_m   = (w + 1) % N;
        pend[w] = 1'b0;
        @(negedge clk);
        drive_bus();
        #1;
        check("busy_run", 32'(busy), 32'd1);
        check("grant_run", 32'(grant), 32'd0);
        check("rv_early", 32'(result_valid), 32'd0);
        cycles = 1;
        while (result_valid !== 1'b1 && cycles < 400) begin
            @(negedge clk);
            cycles++;
        end
        check("latency", 32'(cycles), 32'(exp_lat));
        check("result", 32'(result), 32'(exp_sum));
        check("result_id", 32'(result_id), 32'(w));
        check("err", 32'(err), 32'(exp_err));
        check("grant_done", 32'(grant), 32'd0);
        last_res = exp_sum;
        last_id  = w;
        last_err = exp_err;
        @(negedge clk);
        check("rv_pulse", 32'(result_valid), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("result_hold", 32'(result), 32'(last_res));
        check("id_hold", 32'(result_id), 32'(last_id));
    endtask

    task automatic set_job(input int i, input int l, input int h);
        pend[i] = 1'b1;
        lo_a[i] = l;
        hi_a[i] = h;
    endtask

    initial begin
        pend   = '0;
        ptr_m  = 0;
        for (int i = 0; i < N; i++) begin
            lo_a[i] = 0;
            hi_a[i] = 0;
        end
        rst_n = 1'b0;
        drive_bus();

        // Reset state, with a request already raised
        repeat (2) @(negedge clk);
        req = '1;
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rv", 32'(result_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_id", 32'(result_id), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single job 1..10, then boundaries and inverted range
        set_job(0, 1, 10);
        serve(w_last);
        check("single_result", 32'(last_res), 32'd55);
        set_job(1, 7, 7);
        serve(w_last);
        set_job(2, 0, 255);
        serve(w_last);
        check("full_range", 32'(result), 32'd32640);
        set_job(3, 9, 3);
        serve(w_last);

        // Contention: all four pending, expect 0,1,2,3
        for (int i = 0; i < N; i++) set_job(i, $urandom_range(0, 20), $urandom_range(10, 30));
        for (int k = 0; k < N; k++) begin
            serve(w_last);
            check("contention_order", 32'(w_last), 32'(k));
        end

        // Round-robin: grant 2, then 1001 -> 3 then 0
        set_job(2, 4, 6);
        serve(w_last);
        set_job(0, 1, 3);
        set_job(3, 5, 5);
        serve(w_last);
        check("rr_first", 32'(w_last), 32'd3);
        serve(w_last);
        check("rr_second", 32'(w_last), 32'd0);

        // Reset mid-run: grant to 2 moves the pointer to 3
        pend = '0;
        set_job(2, 1, 10);
        drive_bus();
        #1;
        check("mid_grant", 32'(grant), 32'b0100);
        @(posedge clk);
        pend = '0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        req   = '1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_id", 32'(result_id), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("mid_rst_rv", 32'(result_valid), 32'd0);
        end
        req   = '0;
        rst_n = 1'b1;
        ptr_m = 0;
        @(negedge clk);
        check("post_rst_rv", 32'(result_valid), 32'd0);
        set_job(0, 2, 4);
        set_job(3, 8, 9);
        serve(w_last);
        check("post_rst_winner", 32'(w_last), 32'd0);
        check("post_rst_sum", 32'(last_res), 32'd9);
        serve(w_last);

        // Randomized traffic with requesters holding operands while pending
        for (int it = 0; it < 24; it++) begin
            int nb;
            nb = $urandom_range(0, 15);
            for (int i = 0; i < N; i++) begin
                if (nb[i] && !pend[i]) begin
                    int l, h;
                    l = $urandom_range(0, 255);
                    if ($urandom_range(0, 3) == 0) h = $urandom_range(0, 255);
                    else h = (l + $urandom_range(0, 12) > 255) ? 255 : l + $urandom_range(0, 12);
                    set_job(i, l, h);
                end
            end
            if (pend == '0) set_job($urandom_range(0, N - 1), 3, 5);
            serve(w_last);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
